// File: rtl/interconn_sched.sv
// Per-destination round-robin scheduler for the MVU crossbar: locks each receiver to one
// sender for a whole multi-beat message and drives the crossbar select and beat strobes.
module interconn_sched #(
    parameter int unsigned n = 32,
    localparam int unsigned a = $clog2(n)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [n-1:0]   reqValid,
    input  logic [n*a-1:0] reqDest,
    input  logic [n-1:0]   reqLast,
    input  logic [n-1:0]   recvReady,
    output logic [n*a-1:0] xbarAddr,
    output logic [n-1:0]   recvStrobe,
    output logic [n-1:0]   reqGrant
);

    logic [n-1:0]        lock_q, lock_d;
    logic [n-1:0][a-1:0] owner_q, owner_d;
    logic [n-1:0][a-1:0] ptr_q, ptr_d;

    logic [a-1:0] own;
    logic [a-1:0] cand;
    logic         beat;
    logic         found;

    always_comb begin
        lock_d     = lock_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        xbarAddr   = '0;
        recvStrobe = '0;
        reqGrant   = '0;
        own        = '0;
        cand       = '0;
        beat       = 1'b0;
        found      = 1'b0;
        for (int d = 0; d < n; d++) begin
            own = owner_q[d];
            xbarAddr[d*a +: a] = own;
            beat = reqValid[own] && recvReady[d] && (reqDest[own*a +: a] == a'(d));
            if (lock_q[d]) begin
                recvStrobe[d] = beat;
                if (beat) begin
                    reqGrant[own] = 1'b1;
                    if (reqLast[own]) begin
                        lock_d[d] = 1'b0;
                        ptr_d[d]  = own;
                    end
                end
            end else begin
                // Scan from the sender after the last-served one; k == n wraps back to ptr.
                found = 1'b0;
                for (int k = 1; k <= n; k++) begin
                    cand = ptr_q[d] + a'(k);
                    if (!found && reqValid[cand] && (reqDest[cand*a +: a] == a'(d))) begin
                        found      = 1'b1;
                        owner_d[d] = cand;
                        lock_d[d]  = 1'b1;
                    end
                end
            end
        end
    end

    // ptr resets to n-1 so sender 0 has first priority everywhere.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lock_q  <= '0;
            owner_q <= '0;
            ptr_q   <= '1;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_interconn_sched.sv
// Directed bench for interconn_sched with n=4: reset, single beat, contention, backpressured
// multi-beat lock, parallel destinations and reset mid-message.
module tb_interconn_sched;

    localparam int unsigned N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] reqValid;
    logic [7:0] reqDest;
    logic [3:0] reqLast;
    logic [3:0] recvReady;
    logic [7:0] xbarAddr;
    logic [3:0] recvStrobe;
    logic [3:0] reqGrant;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] exp_g3 [8];
    logic [1:0] exp_x3 [8];
    logic [3:0] exp_g4 [7];
    logic       rdy4   [7];
    logic       last4  [7];
    logic       val4   [7];

    interconn_sched #(.n(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .reqValid   (reqValid),
        .reqDest    (reqDest),
        .reqLast    (reqLast),
        .recvReady  (recvReady),
        .xbarAddr   (xbarAddr),
        .recvStrobe (recvStrobe),
        .reqGrant   (reqGrant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst       = 1'b0;
        reqValid  = '0;
        reqLast   = '0;
        reqDest   = '0;
        recvReady = '1;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic set_req(input int s, input int d, input logic last);
        reqValid[s]        = 1'b1;
        reqDest[s*2 +: 2]  = 2'(d);
        reqLast[s]         = last;
    endtask

    initial begin
        exp_g3 = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h8, 4'h0, 4'h1};
        exp_x3 = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0};
        exp_g4 = '{4'h0, 4'h2, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4};
        rdy4   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        last4  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        val4   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset values with every sender requesting destination 0.
        rst       = 1'b0;
        reqValid  = 4'hF;
        reqDest   = '0;
        reqLast   = 4'hF;
        recvReady = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            settle();
            check("rst_strobe", 32'(recvStrobe), 32'h0);
            check("rst_grant", 32'(reqGrant), 32'h0);
            check("rst_xbar", 32'(xbarAddr), 32'h0);
        end
        step();
        rst = 1'b1;
        settle();
        check("post_rst_strobe", 32'(recvStrobe), 32'h0);
        check("post_rst_grant", 32'(reqGrant), 32'h0);
        step();
        settle();
        check("first_grant", 32'(reqGrant), 32'h1);
        check("first_strobe", 32'(recvStrobe), 32'h1);

        // Single beat: sender 2 -> dest 1.
        reset_dut();
        set_req(2, 1, 1'b1);
        settle();
        check("single_t_strobe", 32'(recvStrobe), 32'h0);
        step();
        settle();
        check("single_xbar1", 32'(xbarAddr[3:2]), 32'd2);
        check("single_strobe", 32'(recvStrobe), 32'h2);
        check("single_grant", 32'(reqGrant), 32'h4);
        step();
        reqValid = '0;
        settle();
        check("single_after_grant", 32'(reqGrant), 32'h0);
        check("single_after_strobe", 32'(recvStrobe), 32'h0);

        // Contention: senders 0, 1, 3 -> dest 2, single-beat messages, requests held.
        reset_dut();
        set_req(0, 2, 1'b1);
        set_req(1, 2, 1'b1);
        set_req(3, 2, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            settle();
            check($sformatf("cont_grant_%0d", i), 32'(reqGrant), 32'(exp_g3[i]));
            check($sformatf("cont_strobe_%0d", i), 32'(recvStrobe),
                  (exp_g3[i] != 4'h0) ? 32'h4 : 32'h0);
            check($sformatf("cont_xbar_%0d", i), 32'(xbarAddr[5:4]), 32'(exp_x3[i]));
        end

        // Multi-beat lock with backpressure: sender 1 (3 beats) vs sender 2, both -> dest 0.
        reset_dut();
        set_req(1, 0, 1'b0);
        set_req(2, 0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            recvReady[0] = rdy4[i];
            reqLast[1]   = last4[i];
            reqValid[1]  = val4[i];
            settle();
            check($sformatf("lock_grant_%0d", i), 32'(reqGrant), 32'(exp_g4[i]));
            check($sformatf("lock_strobe_%0d", i), 32'(recvStrobe),
                  (exp_g4[i] != 4'h0) ? 32'h1 : 32'h0);
        end

        // Parallel destinations: 0->3, 1->2, 2->1, 3->0.
        reset_dut();
        set_req(0, 3, 1'b1);
        set_req(1, 2, 1'b1);
        set_req(2, 1, 1'b1);
        set_req(3, 0, 1'b1);
        settle();
        check("par_t_strobe", 32'(recvStrobe), 32'h0);
        step();
        settle();
        check("par_strobe", 32'(recvStrobe), 32'hF);
        check("par_grant", 32'(reqGrant), 32'hF);
        check("par_xbar", 32'(xbarAddr), 32'h1B);

        // Reset mid-message: sender 3 -> dest 0, 4 beats, reset during beat 2.
        reset_dut();
        set_req(3, 0, 1'b0);
        settle();
        check("rmid_t_strobe", 32'(recvStrobe), 32'h0);
        step();
        settle();
        check("rmid_beat1_grant", 32'(reqGrant), 32'h8);
        step();
        rst = 1'b0;
        set_req(0, 0, 1'b1);
        settle();
        check("rmid_beat2_strobe", 32'(recvStrobe), 32'h1);
        step();
        rst = 1'b1;
        settle();
        check("rmid_after_strobe", 32'(recvStrobe), 32'h0);
        check("rmid_after_grant", 32'(reqGrant), 32'h0);
        check("rmid_after_xbar", 32'(xbarAddr[1:0]), 32'd0);
        step();
        settle();
        check("rmid_rearb_grant", 32'(reqGrant), 32'h1);
        check("rmid_rearb_strobe", 32'(recvStrobe), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
